// File: rtl/regfile_mp_if.sv
// Bundle of the register-file access signals: read ports, write port, clear
// handshake and debug read. The master drives requests and the slave answers.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic                stall;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                clr_req;
  logic                clr_busy;
  logic [AW-1:0]       dbg_addr;
  logic [XLEN-1:0]     dbg_data;

  modport master (
    output stall, rd_addr, wr_en, wr_addr, wr_data, clr_req, dbg_addr,
    input  rd_data, clr_busy, dbg_data
  );

  modport slave (
    input  stall, rd_addr, wr_en, wr_addr, wr_data, clr_req, dbg_addr,
    output rd_data, clr_busy, dbg_data
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with registered, bypassed read data, stall,
// a one-register-per-cycle clear sequencer and a combinational debug read.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  regfile_mp_if.slave  bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [XLEN-1:0]     regs [NREGS];
  logic                wr_acc_p0;
  logic [NRD*XLEN-1:0] rd_next_p0;
  logic [NRD*XLEN-1:0] rd_data_p1;

  assign bus.clr_busy = (state_q == CLEAR);

  // Register 0 writes are dropped here so the array never holds a nonzero r0.
  assign wr_acc_p0 = bus.wr_en && !bus.stall && !bus.clr_busy &&
                     ((ZERO_REG == 0) || (bus.wr_addr != '0));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NREGS; k++) begin
        regs[k] <= '0;
      end
    end else if (state_q == CLEAR) begin
      regs[idx_q] <= '0;
    end else if (wr_acc_p0) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // p0: per-port address decode with same-edge write bypass
  always_comb begin
    rd_next_p0 = '0;
    for (int i = 0; i < NRD; i++) begin
      if ((ZERO_REG != 0) && (bus.rd_addr[i*AW +: AW] == '0)) begin
        rd_next_p0[i*XLEN +: XLEN] = '0;
      end else if (wr_acc_p0 && (bus.wr_addr == bus.rd_addr[i*AW +: AW])) begin
        rd_next_p0[i*XLEN +: XLEN] = bus.wr_data;
      end else begin
        rd_next_p0[i*XLEN +: XLEN] = regs[bus.rd_addr[i*AW +: AW]];
      end
    end
  end

  // p1: registered read data feeding the execute operand latches
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_p1 <= '0;
    end else if (!bus.stall) begin
      rd_data_p1 <= (state_q == CLEAR) ? '0 : rd_next_p0;
    end
  end

  assign bus.rd_data = rd_data_p1;

  assign bus.dbg_data = ((ZERO_REG != 0) && (bus.dbg_addr == '0)) ? '0
                                                                  : regs[bus.dbg_addr];
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a 32x32 two-port instance with r0 hardwired
// and a small 8-entry instance with r0 writable.
module tb_regfile_mp;
  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;
  int   busy_cycles;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) ia ();
  regfile_mp_if #(.XLEN(32), .NREGS(8),  .NRD(1)) ib ();

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ia)
  );
  regfile_mp #(.XLEN(32), .NREGS(8), .NRD(1), .ZERO_REG(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    busy_cycles = 0;
    reset_n     = 1'b0;
    ia.stall = 0; ia.rd_addr = '0; ia.wr_en = 0; ia.wr_addr = '0;
    ia.wr_data = '0; ia.clr_req = 0; ia.dbg_addr = '0;
    ib.stall = 0; ib.rd_addr = '0; ib.wr_en = 0; ib.wr_addr = '0;
    ib.wr_data = '0; ib.clr_req = 0; ib.dbg_addr = '0;

    // reset state, all addresses swept
    for (int a = 0; a < 32; a++) begin
      ia.rd_addr  = {5'(a), 5'(a)};
      ia.dbg_addr = 5'(a);
      #2;
      chk("rst_rd0", ia.rd_data[31:0], 32'h0);
      chk("rst_rd1", ia.rd_data[63:32], 32'h0);
      chk("rst_dbg", ia.dbg_data, 32'h0);
      chk("rst_busy", {31'h0, ia.clr_busy}, 32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // write r5 with both ports reading r5: bypass on both
    ia.wr_en = 1; ia.wr_addr = 5; ia.wr_data = 32'hDEADBEEF;
    ia.rd_addr = {5'd5, 5'd5};
    step();
    chk("byp_rd0", ia.rd_data[31:0], 32'hDEADBEEF);
    chk("byp_rd1", ia.rd_data[63:32], 32'hDEADBEEF);
    ia.wr_en = 0;
    ia.rd_addr = {5'd6, 5'd5};
    ia.dbg_addr = 5;
    step();
    chk("rd_r5", ia.rd_data[31:0], 32'hDEADBEEF);
    chk("rd_r6", ia.rd_data[63:32], 32'h0);
    chk("dbg_r5", ia.dbg_data, 32'hDEADBEEF);

    // r0 write: dropped on A, kept on B
    ia.wr_en = 1; ia.wr_addr = 0; ia.wr_data = 32'h12345678; ia.rd_addr = '0;
    ib.wr_en = 1; ib.wr_addr = 0; ib.wr_data = 32'h12345678; ib.rd_addr = '0;
    step();
    chk("zr_rd0", ia.rd_data[31:0], 32'h0);
    chk("nzr_rd0", ib.rd_data, 32'h12345678);
    ia.wr_en = 0; ib.wr_en = 0;
    ia.dbg_addr = 0; ib.dbg_addr = 0;
    #1;
    chk("zr_dbg0", ia.dbg_data, 32'h0);
    chk("nzr_dbg0", ib.dbg_data, 32'h12345678);

    // stall holds rd_data and blocks writes
    ia.wr_en = 1; ia.wr_addr = 3; ia.wr_data = 32'hA5A5A5A5; ia.rd_addr = {5'd0, 5'd3};
    step();
    chk("st_load", ia.rd_data[31:0], 32'hA5A5A5A5);
    ia.stall = 1; ia.rd_addr = {5'd0, 5'd7};
    ia.wr_addr = 7; ia.wr_data = 32'h1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("st_hold", ia.rd_data[31:0], 32'hA5A5A5A5);
    end
    ia.stall = 0; ia.wr_en = 0; ia.dbg_addr = 7;
    #1;
    chk("st_r7", ia.dbg_data, 32'h0);
    step();
    chk("st_rd7", ia.rd_data[31:0], 32'h0);

    // fill r1..r31 with 0x100+index
    ia.wr_en = 1;
    for (int r = 1; r < 32; r++) begin
      ia.wr_addr = 5'(r);
      ia.wr_data = 32'h100 + 32'(r);
      step();
    end
    ia.wr_en = 0;
    ia.dbg_addr = 31;
    #1;
    chk("fill_r31", ia.dbg_data, 32'h11F);

    // clear sequence, second request at N+3 ignored, write at N+10 dropped
    ia.rd_addr = {5'd0, 5'd10};
    ia.clr_req = 1;
    step();
    chk("clr_idle_rd", ia.rd_data[31:0], 32'h10A);
    chk("clr_busy_n", {31'h0, ia.clr_busy}, 32'h1);
    if (ia.clr_busy) busy_cycles++;
    for (int k = 1; k <= 32; k++) begin
      ia.clr_req  = (k == 3);
      ia.wr_en    = (k == 10);
      ia.wr_addr  = 2;
      ia.wr_data  = 32'hFFFF;
      ia.dbg_addr = (k <= 5) ? 5'd4 : 5'd2;
      step();
      if (ia.clr_busy) busy_cycles++;
      if (k == 1)  chk("clr_rd_zero", ia.rd_data[31:0], 32'h0);
      if (k == 4)  chk("clr_r4_old", ia.dbg_data, 32'h104);
      if (k == 5)  chk("clr_r4_zero", ia.dbg_data, 32'h0);
      if (k == 10) chk("clr_wr_drop", ia.dbg_data, 32'h0);
      if (k == 31) chk("clr_busy_31", {31'h0, ia.clr_busy}, 32'h1);
      if (k == 32) chk("clr_busy_32", {31'h0, ia.clr_busy}, 32'h0);
    end
    ia.clr_req = 0; ia.wr_en = 0;
    chk("clr_busy_cnt", 32'(busy_cycles), 32'd32);
    for (int a = 0; a < 32; a++) begin
      ia.dbg_addr = 5'(a);
      #1;
      chk("clr_all", ia.dbg_data, 32'h0);
    end
    ia.wr_en = 1; ia.wr_addr = 4; ia.wr_data = 32'h44; ia.dbg_addr = 4;
    step();
    chk("clr_first_wr", ia.dbg_data, 32'h44);

    // reset in the middle of a clear
    ia.wr_addr = 20; ia.wr_data = 32'h2020; ia.dbg_addr = 20;
    step();
    ia.wr_en = 0; ia.clr_req = 1; ia.rd_addr = {5'd0, 5'd20};
    step();
    ia.clr_req = 0;
    for (int c = 0; c < 10; c++) step();
    chk("mid_r20", ia.dbg_data, 32'h2020);
    chk("mid_busy", {31'h0, ia.clr_busy}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("mid_busy_rst", {31'h0, ia.clr_busy}, 32'h0);
    chk("mid_r20_rst", ia.dbg_data, 32'h0);
    ia.dbg_addr = 4;
    #1;
    chk("mid_r4_rst", ia.dbg_data, 32'h0);
    chk("mid_b_r0_rst", ib.dbg_data, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    ia.wr_en = 1; ia.wr_addr = 6; ia.wr_data = 32'h66;
    ia.rd_addr = {5'd0, 5'd6}; ia.dbg_addr = 6;
    step();
    chk("post_rst_rd", ia.rd_data[31:0], 32'h66);
    chk("post_rst_dbg", ia.dbg_data, 32'h66);
    chk("post_rst_busy", {31'h0, ia.clr_busy}, 32'h0);
    ia.wr_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
